// File: rtl/y_int_ctl_pkg.sv
// Shared constants for the interrupt controller: FSM encodings, default
// vector base and the vector address helper.
package y_int_ctl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FIRE    = 2'd1,
    SERVICE = 2'd2
  } ctlState;

  localparam logic [31:0] VEC_BASE_DEFAULT = 32'h00000080;

  // Wraps modulo 2^32 by construction; no carry out is kept.
  function automatic logic [31:0] vecAddr(input logic [31:0] base,
                                          input logic [1:0]  id,
                                          input int unsigned strideLog2);
    return base + ({30'd0, id} << strideLog2);
  endfunction

endpackage

// File: rtl/y_int_ctl_pri_enc4.sv
// 4-to-2 priority encoder; the lowest set index wins.
module y_int_ctl_pri_enc4 (
  input  logic [3:0] req,
  output logic [1:0] id,
  output logic       any
);

  always_comb begin
    id = 2'd0;
    if (req[0])      id = 2'd0;
    else if (req[1]) id = 2'd1;
    else if (req[2]) id = 2'd2;
    else if (req[3]) id = 2'd3;
  end

  assign any = |req;

endmodule

// File: rtl/y_int_ctl.sv
// Single-level, non-nesting interrupt controller: edge-latched requests,
// maskable, one-cycle redirect strobe with vector address and saved PC.
module y_int_ctl
  import y_int_ctl_pkg::*;
#(
  parameter logic [31:0] VEC_BASE        = VEC_BASE_DEFAULT,
  parameter int unsigned VEC_STRIDE_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  irq,
  input  logic        maskWe,
  input  logic [3:0]  maskIn,
  input  logic        eoi,
  input  logic [31:0] pcIn,
  output logic        INT,
  output logic [31:0] entryPoint,
  output logic [31:0] epc,
  output logic        inService,
  output logic [1:0]  curId,
  output logic [3:0]  pending
);

  ctlState    state;
  ctlState    stateNext;
  logic [3:0] irqQ;
  logic [3:0] mask;
  logic [3:0] rise;
  logic [3:0] clearMask;
  logic [3:0] pendingNext;
  logic [1:0] encId;
  logic       encAny;
  logic       loadVector;

  assign rise = irq & ~irqQ;

  y_int_ctl_pri_enc4 priEnc (
    .req (pending & mask),
    .id  (encId),
    .any (encAny)
  );

  // A rise landing on the same edge as the clear re-arms the line.
  always_comb begin
    stateNext  = state;
    loadVector = 1'b0;
    clearMask  = 4'd0;
    case (state)
      IDLE: begin
        if (encAny) begin
          loadVector = 1'b1;
          stateNext  = FIRE;
        end
      end
      FIRE: begin
        clearMask[curId] = 1'b1;
        stateNext        = SERVICE;
      end
      SERVICE: begin
        if (eoi) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    pendingNext = (pending & ~clearMask) | rise;
  end

  // irqQ tracks irq even in reset so a held line gives no rise on release.
  always_ff @(posedge clk) begin
    irqQ <= irq;
    if (reset) begin
      state      <= IDLE;
      pending    <= 4'd0;
      mask       <= 4'd0;
      curId      <= 2'd0;
      epc        <= 32'd0;
      entryPoint <= VEC_BASE;
    end else begin
      state   <= stateNext;
      pending <= pendingNext;
      if (maskWe) mask <= maskIn;
      if (loadVector) begin
        curId      <= encId;
        epc        <= pcIn;
        entryPoint <= vecAddr(VEC_BASE, encId, VEC_STRIDE_LOG2);
      end
    end
  end

  assign INT       = (state == FIRE);
  assign inService = (state == SERVICE);

endmodule

// File: tb/tb_y_int_ctl.sv
// Directed bench for y_int_ctl: reset, priority, masking, re-arm on clear
// edge, eoi handling and reset abandonment of an active interrupt.
module tb_y_int_ctl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq;
  logic        maskWe;
  logic [3:0]  maskIn;
  logic        eoi;
  logic [31:0] pcIn;
  logic        INT;
  logic [31:0] entryPoint;
  logic [31:0] epc;
  logic        inService;
  logic [1:0]  curId;
  logic [3:0]  pending;

  int errors = 0;
  int checks = 0;

  y_int_ctl dut (
    .clk        (clk),
    .reset      (reset),
    .irq        (irq),
    .maskWe     (maskWe),
    .maskIn     (maskIn),
    .eoi        (eoi),
    .pcIn       (pcIn),
    .INT        (INT),
    .entryPoint (entryPoint),
    .epc        (epc),
    .inService  (inService),
    .curId      (curId),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; irq = 4'd0; maskWe = 1'b0; maskIn = 4'd0;
    eoi = 1'b0; pcIn = 32'h0000_1000;
    applyStimulus();
    applyStimulus();
    checkOutput("rst_int",   {31'd0, INT},       32'd0);
    checkOutput("rst_insvc", {31'd0, inService}, 32'd0);
    checkOutput("rst_pend",  {28'd0, pending},   32'd0);
    checkOutput("rst_entry", entryPoint,         32'h0000_0080);
    checkOutput("rst_epc",   epc,                32'd0);
    checkOutput("rst_curid", {30'd0, curId},     32'd0);

    reset = 1'b0; maskWe = 1'b1; maskIn = 4'hF;
    applyStimulus();
    maskWe = 1'b0;

    // Single request on line 2
    irq = 4'b0100;
    applyStimulus();
    checkOutput("l2_pend", {28'd0, pending}, 32'h4);
    checkOutput("l2_int0", {31'd0, INT},     32'd0);
    irq = 4'b0000; pcIn = 32'h0000_2004;
    applyStimulus();
    checkOutput("l2_int",   {31'd0, INT},   32'd1);
    checkOutput("l2_curid", {30'd0, curId}, 32'd2);
    checkOutput("l2_entry", entryPoint,     32'h0000_00A0);
    checkOutput("l2_epc",   epc,            32'h0000_2004);
    pcIn = 32'h0000_3000;
    applyStimulus();
    checkOutput("l2_int_low", {31'd0, INT},       32'd0);
    checkOutput("l2_insvc",   {31'd0, inService}, 32'd1);
    checkOutput("l2_clear",   {28'd0, pending},   32'd0);
    checkOutput("l2_epc_hold", epc,               32'h0000_2004);
    eoi = 1'b1;
    applyStimulus();
    eoi = 1'b0;
    checkOutput("l2_eoi_idle", {31'd0, inService}, 32'd0);
    checkOutput("l2_entry_hold", entryPoint,       32'h0000_00A0);

    // eoi in IDLE with nothing pending
    eoi = 1'b1;
    applyStimulus();
    eoi = 1'b0;
    checkOutput("idle_eoi_int",   {31'd0, INT},       32'd0);
    checkOutput("idle_eoi_insvc", {31'd0, inService}, 32'd0);
    applyStimulus();
    checkOutput("idle_eoi_int2",  {31'd0, INT},       32'd0);

    // Simultaneous rise on lines 3 and 1
    irq = 4'b1010;
    applyStimulus();
    checkOutput("p31_pend", {28'd0, pending}, 32'hA);
    irq = 4'b0000;
    applyStimulus();
    checkOutput("p31_int",   {31'd0, INT},   32'd1);
    checkOutput("p31_curid", {30'd0, curId}, 32'd1);
    checkOutput("p31_entry", entryPoint,     32'h0000_0090);
    applyStimulus();
    checkOutput("p31_pend_svc", {28'd0, pending}, 32'h8);
    applyStimulus();
    checkOutput("p31_nonest", {31'd0, INT}, 32'd0);
    eoi = 1'b1;
    applyStimulus();
    eoi = 1'b0;
    checkOutput("p31_idle_int", {31'd0, INT}, 32'd0);
    applyStimulus();
    checkOutput("p3_int",   {31'd0, INT},   32'd1);
    checkOutput("p3_curid", {30'd0, curId}, 32'd3);
    checkOutput("p3_entry", entryPoint,     32'h0000_00B0);
    applyStimulus();
    checkOutput("p3_pend", {28'd0, pending}, 32'd0);
    eoi = 1'b1;
    applyStimulus();
    eoi = 1'b0;

    // Masked request retained, fires after unmask
    maskWe = 1'b1; maskIn = 4'h0;
    applyStimulus();
    maskWe = 1'b0; irq = 4'b0001;
    applyStimulus();
    irq = 4'b0000;
    applyStimulus();
    checkOutput("msk_int0", {31'd0, INT},     32'd0);
    applyStimulus();
    checkOutput("msk_int1", {31'd0, INT},     32'd0);
    checkOutput("msk_pend", {28'd0, pending}, 32'h1);
    maskWe = 1'b1; maskIn = 4'h1;
    applyStimulus();
    maskWe = 1'b0;
    checkOutput("msk_wr_int", {31'd0, INT}, 32'd0);
    applyStimulus();
    checkOutput("msk_fire",  {31'd0, INT}, 32'd1);
    checkOutput("msk_entry", entryPoint,   32'h0000_0080);
    applyStimulus();
    // Masking the active line during SERVICE must not abort it
    maskWe = 1'b1; maskIn = 4'h0;
    applyStimulus();
    maskWe = 1'b0;
    checkOutput("msk_keep_svc", {31'd0, inService}, 32'd1);
    maskWe = 1'b1; maskIn = 4'hF;
    applyStimulus();
    maskWe = 1'b0; eoi = 1'b1;
    applyStimulus();
    eoi = 1'b0;

    // Re-rise of line 0 on the FIRE->SERVICE edge
    irq = 4'b0001;
    applyStimulus();
    irq = 4'b0000;
    applyStimulus();
    checkOutput("rearm_fire", {31'd0, INT}, 32'd1);
    irq = 4'b0001;
    applyStimulus();
    irq = 4'b0000;
    checkOutput("rearm_pend",  {28'd0, pending},   32'h1);
    checkOutput("rearm_insvc", {31'd0, inService}, 32'd1);
    applyStimulus();
    checkOutput("rearm_nonest", {31'd0, INT}, 32'd0);
    eoi = 1'b1;
    applyStimulus();
    eoi = 1'b0;
    applyStimulus();
    checkOutput("rearm_refire", {31'd0, INT},   32'd1);
    checkOutput("rearm_curid",  {30'd0, curId}, 32'd0);
    applyStimulus();
    checkOutput("rearm_pend0", {28'd0, pending}, 32'd0);

    // Reset during SERVICE, with irq[1] held high across release
    reset = 1'b1; irq = 4'b0010; eoi = 1'b1;
    applyStimulus();
    eoi = 1'b0;
    checkOutput("rsvc_insvc", {31'd0, inService}, 32'd0);
    checkOutput("rsvc_entry", entryPoint,         32'h0000_0080);
    checkOutput("rsvc_int",   {31'd0, INT},       32'd0);
    applyStimulus();
    reset = 1'b0; maskWe = 1'b1; maskIn = 4'hF;
    applyStimulus();
    maskWe = 1'b0;
    checkOutput("held_pend", {28'd0, pending}, 32'd0);
    applyStimulus();
    checkOutput("held_int0", {31'd0, INT}, 32'd0);
    applyStimulus();
    checkOutput("held_int1", {31'd0, INT}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
